// File: rtl/alu_addsub_sequencer.sv
// Command sequencer and result stage around an external ripple adder/subtractor; ADD/SUB take one adder pass, ADC/SBC may take two.
// Result valid one or two cycles after accept; holds result and cmd_ready=0 while res_ready is low.
module alu_addsub_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_c_in,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_c_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_c,
  output logic             res_v,
  output logic             res_z,
  output logic             res_n,
  output logic             carry_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } res_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WIDTH-1:0] sum1_q, sum1_d;
  logic             c1_q, c1_d;
  res_t             res_q, res_d;
  logic             carry_q, carry_d;

  logic             finish;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_c;
  logic             need_pass2;
  logic             a_msb, b_msb, r_msb;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    sum1_d     = sum1_q;
    c1_d       = c1_q;
    res_d      = res_q;
    carry_d    = carry_q;
    as_a       = '0;
    as_b       = '0;
    as_c_in    = 1'b0;
    finish     = 1'b0;
    fin_sum    = as_sum;
    fin_c      = as_c_out;
    cmd_ready  = (state_q == S_IDLE) && !rst;
    // A second pass applies the stored carry: +1 for ADC with C set, -1 for SBC with borrow pending.
    need_pass2 = ((cmd_q.op == OP_ADC) && carry_q) || ((cmd_q.op == OP_SBC) && !carry_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.op = cmd_op;
          cmd_d.a  = cmd_a;
          cmd_d.b  = cmd_b;
          state_d  = S_PASS1;
        end
      end
      S_PASS1: begin
        as_a    = cmd_q.a;
        as_b    = cmd_q.b;
        as_c_in = cmd_q.op[0];
        sum1_d  = as_sum;
        c1_d    = as_c_out;
        if (need_pass2) begin
          state_d = S_PASS2;
        end else begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_PASS2: begin
        // c_in=1 inverts B: all-ones becomes +0 (+1 carry), one becomes -1.
        as_a    = sum1_q;
        as_b    = (cmd_q.op == OP_ADC) ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, 1'b1};
        as_c_in = 1'b1;
        fin_c   = (cmd_q.op == OP_ADC) ? (c1_q | as_c_out) : (c1_q & as_c_out);
        finish  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    a_msb = cmd_q.a[WIDTH-1];
    b_msb = cmd_q.b[WIDTH-1];
    r_msb = fin_sum[WIDTH-1];

    if (finish) begin
      res_d.sum = fin_sum;
      res_d.c   = fin_c;
      res_d.z   = (fin_sum == '0);
      res_d.n   = r_msb;
      res_d.v   = (cmd_q.op[0] ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
      carry_d   = fin_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      sum1_q  <= '0;
      c1_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sum1_q  <= sum1_d;
      c1_q    <= c1_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign res_valid  = (state_q == S_DONE);
  assign res_sum    = res_q.sum;
  assign res_c      = res_q.c;
  assign res_v      = res_q.v;
  assign res_z      = res_q.z;
  assign res_n      = res_q.n;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_addsub_sequencer.sv
// Bench for alu_addsub_sequencer with a behavioural 8-bit adder/subtractor on the as_* ports.
module tb_alu_addsub_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic [W-1:0] as_a, as_b;
  logic         as_c_in;
  logic [W-1:0] as_sum;
  logic         as_c_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_c, res_v, res_z, res_n;
  logic         carry_flag;

  alu_addsub_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .as_a(as_a), .as_b(as_b), .as_c_in(as_c_in),
    .as_sum(as_sum), .as_c_out(as_c_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_c(res_c), .res_v(res_v), .res_z(res_z), .res_n(res_n),
    .carry_flag(carry_flag)
  );

  logic [W:0] adder_full;
  assign adder_full = {1'b0, as_a} + {1'b0, as_b ^ {W{as_c_in}}} + {{W{1'b0}}, as_c_in};
  assign as_sum     = adder_full[W-1:0];
  assign as_c_out   = adder_full[W];

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", res_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_sum", {24'd0, res_sum}, {24'd0, e.sum});
        chk("res_c", {31'd0, res_c}, {31'd0, e.c});
        chk("res_v", {31'd0, res_v}, {31'd0, e.v});
        chk("res_z", {31'd0, res_z}, {31'd0, e.z});
        chk("res_n", {31'd0, res_n}, {31'd0, e.n});
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
      end
    end
  end

  // Issue one command and follow it to DONE; returns #1 after the DONE-entry edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input exp_t e, input int exp_lat,
                       input logic [W-1:0] p2_a, input logic [W-1:0] p2_b);
    int wait_cyc;
    int lat;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    if (push) exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a     = W'($urandom);
    cmd_b     = W'($urandom);
    chk("pass1_as_a", {24'd0, as_a}, {24'd0, a});
    chk("pass1_as_c_in", {31'd0, as_c_in}, {31'd0, op[0]});
    lat = 0;
    while (!res_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && exp_lat == 2 && !res_valid) begin
        chk("pass2_as_a", {24'd0, as_a}, {24'd0, p2_a});
        chk("pass2_as_b", {24'd0, as_b}, {24'd0, p2_b});
        chk("pass2_as_c_in", {31'd0, as_c_in}, 32'd1);
      end
    end
    chk("latency", lat, exp_lat);
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic v,
                              input logic z, input logic n);
    exp_t e;
    e.sum = s; e.c = c; e.v = v; e.z = z; e.n = n;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_sum", {24'd0, res_sum}, 32'd0);
    chk("rst_flags", {28'd0, res_c, res_v, res_z, res_n}, 32'd0);
    chk("rst_carry_flag", {31'd0, carry_flag}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_as_c_in", {31'd0, as_c_in}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // op, a, b, push, expected {sum,c,v,z,n}, latency, pass2 as_a/as_b
    issue(2'b00, 8'd13,  8'd7,   1'b1, mk(8'h14, 0, 0, 0, 0), 1, 8'h00, 8'h00);
    issue(2'b01, 8'h40,  8'h20,  1'b1, mk(8'h20, 1, 0, 0, 0), 1, 8'h00, 8'h00);
    issue(2'b01, 8'h00,  8'h01,  1'b1, mk(8'hFF, 0, 0, 0, 1), 1, 8'h00, 8'h00);
    issue(2'b11, 8'h00,  8'h00,  1'b1, mk(8'hFF, 0, 0, 0, 1), 2, 8'h00, 8'h01);
    issue(2'b11, 8'h10,  8'h01,  1'b1, mk(8'h0E, 1, 0, 0, 0), 2, 8'h0F, 8'h01);
    issue(2'b00, 8'hFF,  8'h01,  1'b1, mk(8'h00, 1, 0, 1, 0), 1, 8'h00, 8'h00);
    issue(2'b10, 8'h7F,  8'h00,  1'b1, mk(8'h80, 0, 1, 0, 1), 2, 8'h7F, 8'hFF);
    issue(2'b10, 8'h05,  8'h03,  1'b1, mk(8'h08, 0, 0, 0, 0), 1, 8'h00, 8'h00);

    // Stall in DONE with res_ready low; a pulsed command must be ignored.
    @(posedge clk); #1;
    res_ready = 1'b0;
    issue(2'b00, 8'h80, 8'h80, 1'b1, mk(8'h00, 1, 1, 1, 0), 1, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_res_sum", {24'd0, res_sum}, 32'h00);
      chk("stall_flags", {28'd0, res_c, res_v, res_z, res_n}, 32'b1110);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (i == 2) begin
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h11; cmd_b = 8'h22;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_stall_res_valid", {31'd0, res_valid}, 32'd0);
    chk("after_stall_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    issue(2'b11, 8'h20, 8'h10, 1'b1, mk(8'h10, 1, 0, 0, 0), 1, 8'h00, 8'h00);
    issue(2'b01, 8'h80, 8'h01, 1'b1, mk(8'h7F, 1, 1, 0, 0), 1, 8'h00, 8'h00);
    issue(2'b00, 8'hFF, 8'h01, 1'b1, mk(8'h00, 1, 0, 1, 0), 1, 8'h00, 8'h00);

    // Reset while an ADC is in its second pass: command dropped, state cleared.
    @(posedge clk); #1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'h01; cmd_b = 8'h01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_pass2_as_c_in", {31'd0, as_c_in}, 32'd1);
    chk("pre_rst_pass2_as_a", {24'd0, as_a}, 32'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pass2_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_pass2_carry_flag", {31'd0, carry_flag}, 32'd0);
    chk("rst_pass2_res_sum", {24'd0, res_sum}, 32'd0);
    chk("rst_pass2_as_c_in", {31'd0, as_c_in}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_pass2_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pass2_no_result", {31'd0, res_valid}, 32'd0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
